// File: rtl/ebpc_pkg.sv
// Shared types and constants for the bit-plane compression lane.
// Contents:
//   - block geometry (DATA_W, BLOCK_SIZE) and derived widths
//   - encoding_t: MSB-aligned code symbol with its length and a zero flag
//   - DBX and zero-run code prefixes with their lengths
//   - dbx_seq_state_e: sequencer state encoding
//   - msb_align(): places an LSB-justified code of a given length at the MSB end
package ebpc_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BLOCK_SIZE = 8;
  localparam int unsigned PLANE_W    = BLOCK_SIZE - 1;
  localparam int unsigned SYMB_W     = 16;
  localparam int unsigned SYMB_LEN_W = $clog2(SYMB_W + 1);
  localparam int unsigned PCNT_W     = $clog2(DATA_W + 1);
  localparam int unsigned POS_W      = $clog2(PLANE_W);

  typedef logic [SYMB_LEN_W-1:0] symb_len_t;
  typedef logic [0:DATA_W][PLANE_W-1:0] dbp_block_t;

  typedef struct packed {
    logic [SYMB_W-1:0] symb;
    symb_len_t         len;
    logic              zero;
  } encoding_t;

  localparam logic [4:0] ALL_ONES_PREFIX   = 5'b00000;
  localparam logic [4:0] TWO_CONSEC_PREFIX = 5'b00010;
  localparam logic [4:0] SINGLE_ONE_PREFIX = 5'b00011;
  localparam logic       UNCOMP_PREFIX     = 1'b1;

  localparam symb_len_t ALL_ONES_LEN = symb_len_t'(5);
  localparam symb_len_t DBX_POS_LEN  = symb_len_t'(5 + POS_W);
  localparam symb_len_t UNCOMP_LEN   = symb_len_t'(BLOCK_SIZE);

  localparam logic [2:0] ZRL_SINGLE     = 3'b001;
  localparam logic [1:0] ZRL_PREFIX     = 2'b01;
  localparam symb_len_t  ZRL_SINGLE_LEN = symb_len_t'(3);
  localparam symb_len_t  ZRL_PREFIX_LEN = symb_len_t'(2);

  typedef enum logic [1:0] {
    DBX_SEQ_IDLE,
    DBX_SEQ_ENCODE,
    DBX_SEQ_FLUSH_ZR
  } dbx_seq_state_e;

  function automatic encoding_t msb_align(input logic [SYMB_W-1:0] val, input symb_len_t len);
    encoding_t e;
    e.symb = val << (SYMB_W - int'(len));
    e.len  = len;
    e.zero = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/dbx_compressor.sv
// Combinational DBX encoder for one plane of a registered block.
// DBX of plane i is plane i XOR plane i+1; the last plane is passed as-is.
// Ports:
//   dbp_i     : full block of delta bit-planes
//   dbp_cnt_i : plane index to encode (0..DATA_W)
//   symb_o    : code symbol; .zero set when the DBX is all zero
module dbx_compressor
  import ebpc_pkg::*;
(
  input  dbp_block_t        dbp_i,
  input  logic [PCNT_W-1:0] dbp_cnt_i,
  output encoding_t         symb_o
);

  logic [PLANE_W-1:0] dbx_all [DATA_W+1];
  logic [PLANE_W-1:0] dbx;
  logic [PLANE_W-1:0] pair;
  logic [POS_W-1:0]   one_pos;
  logic [POS_W-1:0]   pair_pos;
  int                 ones;

  always_comb begin
    for (int i = 0; i < DATA_W; i++) dbx_all[i] = dbp_i[i] ^ dbp_i[i+1];
    dbx_all[DATA_W] = dbp_i[DATA_W];
  end

  always_comb begin
    dbx = '0;
    for (int i = 0; i <= DATA_W; i++)
      if (dbp_cnt_i == PCNT_W'(i)) dbx = dbx_all[i];
  end

  // a set bit in pair marks the lower bit of two adjacent ones
  assign pair = dbx & (dbx >> 1);

  // positions are counted from the MSB of the plane
  always_comb begin
    ones     = 0;
    one_pos  = '0;
    pair_pos = '0;
    for (int i = 0; i < PLANE_W; i++) begin
      if (dbx[i]) begin
        ones    = ones + 1;
        one_pos = POS_W'(PLANE_W - 1 - i);
      end
    end
    for (int i = 0; i < PLANE_W - 1; i++)
      if (pair[i]) pair_pos = POS_W'(PLANE_W - 2 - i);
  end

  always_comb begin
    symb_o = msb_align(SYMB_W'({UNCOMP_PREFIX, dbx}), UNCOMP_LEN);
    if (dbx == '0) begin
      symb_o      = '0;
      symb_o.zero = 1'b1;
    end else if (&dbx) begin
      symb_o = msb_align(SYMB_W'(ALL_ONES_PREFIX), ALL_ONES_LEN);
    end else if (ones == 1) begin
      symb_o = msb_align(SYMB_W'({SINGLE_ONE_PREFIX, one_pos}), DBX_POS_LEN);
    end else if (ones == 2 && pair != '0) begin
      symb_o = msb_align(SYMB_W'({TWO_CONSEC_PREFIX, pair_pos}), DBX_POS_LEN);
    end
  end

endmodule

// File: rtl/dbx_seq_ctrl.sv
// Sequencer for one bit-plane compression lane: accepts a block, walks its
// planes 0..DATA_W through dbx_compressor, run-length encodes zero DBX
// symbols and drives a registered valid/ready symbol stream.
// Optional macro EBPC_SYMB_LAST_EN adds last_o (final symbol of a block).
// Ports:
//   clk_i, rst_ni             : clock, async active-low reset
//   dbp_i/dbp_valid_i/dbp_ready_o : block input handshake
//   symb_o/symb_valid_o/symb_ready_i : symbol output handshake
//   last_o                    : (EBPC_SYMB_LAST_EN) last symbol of block
//   busy_o                    : block in progress
//
// state    | meaning
// IDLE     | waiting for a block, dbp_ready_o high
// ENCODE   | one plane per cycle, counting zero runs
// FLUSH_ZR | emit the run pending after the last plane
module dbx_seq_ctrl
  import ebpc_pkg::*;
#(
  parameter int unsigned MAX_ZRL = 33,
  parameter int unsigned ZRLE_W  = $clog2(MAX_ZRL - 1)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  dbp_block_t dbp_i,
  input  logic       dbp_valid_i,
  output logic       dbp_ready_o,
  output encoding_t  symb_o,
  output logic       symb_valid_o,
  input  logic       symb_ready_i,
`ifdef EBPC_SYMB_LAST_EN
  output logic       last_o,
`endif
  output logic       busy_o
);

  localparam int unsigned       ZRL_W      = $clog2(MAX_ZRL + 1);
  localparam logic [ZRL_W-1:0]  ZRL_MAX_M1 = ZRL_W'(MAX_ZRL - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(DATA_W);

  dbx_seq_state_e    state_q, state_d;
  dbp_block_t        dbp_q;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [ZRL_W-1:0]  zrl_q, zrl_d;
  encoding_t         cmp_symb, emit_symb;
  logic              emit, blk_load, load_ok, advance, last_plane;

  // k-2 fits in ZRLE_W bits, so shifting the prefix up leaves room without masking
  function automatic encoding_t run_symb(input logic [ZRL_W-1:0] k);
    logic [SYMB_W-1:0] v;
    v = (SYMB_W'(ZRL_PREFIX) << ZRLE_W) | SYMB_W'(k - ZRL_W'(2));
    if (k == ZRL_W'(1)) return msb_align(SYMB_W'(ZRL_SINGLE), ZRL_SINGLE_LEN);
    return msb_align(v, symb_len_t'(int'(ZRL_PREFIX_LEN) + ZRLE_W));
  endfunction

  dbx_compressor u_cmp (
    .dbp_i    (dbp_q),
    .dbp_cnt_i(pcnt_q),
    .symb_o   (cmp_symb)
  );

  assign load_ok     = !symb_valid_o || symb_ready_i;
  assign last_plane  = (pcnt_q == PCNT_LAST);
  assign dbp_ready_o = (state_q == DBX_SEQ_IDLE);
  assign busy_o      = (state_q != DBX_SEQ_IDLE);

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    zrl_d     = zrl_q;
    emit      = 1'b0;
    emit_symb = cmp_symb;
    blk_load  = 1'b0;
    advance   = 1'b0;
    case (state_q)
      DBX_SEQ_IDLE: begin
        if (dbp_valid_i) begin
          blk_load = 1'b1;
          pcnt_d   = '0;
          zrl_d    = '0;
          state_d  = DBX_SEQ_ENCODE;
        end
      end
      DBX_SEQ_ENCODE: begin
        if (cmp_symb.zero) begin
          if (zrl_q == ZRL_MAX_M1) begin
            emit      = 1'b1;
            emit_symb = run_symb(ZRL_W'(MAX_ZRL));
            if (load_ok) begin
              zrl_d   = '0;
              advance = 1'b1;
            end
          end else begin
            zrl_d   = zrl_q + 1'b1;
            advance = 1'b1;
          end
        end else if (zrl_q != '0) begin
          // close the run first; this plane is re-evaluated next cycle
          emit      = 1'b1;
          emit_symb = run_symb(zrl_q);
          if (load_ok) zrl_d = '0;
        end else begin
          emit = 1'b1;
          if (load_ok) advance = 1'b1;
        end
        if (advance) begin
          if (last_plane) state_d = (zrl_d != '0) ? DBX_SEQ_FLUSH_ZR : DBX_SEQ_IDLE;
          else            pcnt_d  = pcnt_q + 1'b1;
        end
      end
      DBX_SEQ_FLUSH_ZR: begin
        emit      = 1'b1;
        emit_symb = run_symb(zrl_q);
        if (load_ok) begin
          zrl_d   = '0;
          state_d = DBX_SEQ_IDLE;
        end
      end
      default: state_d = DBX_SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DBX_SEQ_IDLE;
      dbp_q   <= '0;
      pcnt_q  <= '0;
      zrl_q   <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      zrl_q   <= zrl_d;
      if (blk_load) dbp_q <= dbp_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      symb_o       <= '0;
      symb_valid_o <= 1'b0;
    end else if (emit && load_ok) begin
      symb_o       <= emit_symb;
      symb_valid_o <= 1'b1;
    end else if (symb_ready_i) begin
      symb_valid_o <= 1'b0;
    end
  end

`ifdef EBPC_SYMB_LAST_EN
  logic emit_last;

  // only meaningful when emit is set: FLUSH_ZR, or the last plane's own
  // symbol / a full run closing on the last plane
  assign emit_last = (state_q == DBX_SEQ_FLUSH_ZR) ||
                     (last_plane && (cmp_symb.zero || zrl_q == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               last_o <= 1'b0;
    else if (emit && load_ok)  last_o <= emit_last;
  end
`endif

endmodule

// File: doc/dbx_seq_ctrl.md
# dbx_seq_ctrl

Sequencer for one bit-plane compression lane. It accepts one block of delta bit-planes through a valid/ready handshake, walks the planes in order 0..DATA_W through an instantiated `dbx_compressor`, and applies zero-run-length encoding to consecutive zero DBX symbols. It emits a registered stream of variable-length code symbols toward the packer.

## Interface
Parameters:
- `MAX_ZRL`, default 33: longest zero run carried in one run symbol; must be ≥ 2.
- `ZRLE_W`, default `$clog2(MAX_ZRL-1)`: width of the run-length field.

Ports (clock and reset first):
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `dbp_i` in [0:DATA_W][BLOCK_SIZE-2:0]: delta bit-planes of one block.
- `dbp_valid_i` in 1: block valid.
- `dbp_ready_o` out 1: block accepted when high together with `dbp_valid_i`.
- `symb_o` out `encoding_t`: code symbol, MSB-aligned; `.zero` is always 0.
- `symb_valid_o` out 1: symbol valid.
- `symb_ready_i` in 1: downstream accepts symbol.
- `busy_o` out 1: block in progress (state ≠ IDLE).

## Operation
- States are IDLE, ENCODE and FLUSH_ZR.
- **IDLE**
  - `dbp_ready_o`=1.
  - On `dbp_valid_i` the block is registered, plane counter `pcnt` is cleared to 0, run counter `zrl` is cleared to 0, and the state moves to ENCODE.
- **ENCODE**
  - Each cycle, `dbx_compressor` is fed the registered block with `dbp_cnt`=`pcnt`.
  - Zero symbol, `zrl`+1 < `MAX_ZRL`: `zrl`++, `pcnt` advances, nothing is emitted.
  - Zero symbol, `zrl`+1 = `MAX_ZRL`: a run symbol of length `MAX_ZRL` is emitted, `zrl` is cleared, and `pcnt` advances. If the output register is busy, the controller stalls.
  - Nonzero symbol, `zrl`>0: the run symbol for `zrl` is emitted and `zrl` is cleared. `pcnt` does **not** advance, so the same plane is re-evaluated next cycle.
  - Nonzero symbol, `zrl`=0: the symbol is emitted and `pcnt` advances.
  - After plane DATA_W is consumed: if `zrl`>0, go to FLUSH_ZR; otherwise go to IDLE.
- **FLUSH_ZR**
  - Emit the run symbol for `zrl`, clear `zrl`, then go to IDLE.
- Run symbol encoding:
  - k=1: `3'b001`, len 3.
  - 2≤k≤`MAX_ZRL`: `2'b01` followed by (k-2) in `ZRLE_W` bits, len 2+`ZRLE_W`.
- Output register loads whenever `!symb_valid_o || symb_ready_i`. An emission that cannot load stalls the controller; `pcnt`, `zrl` and state are all held.
- `symb_o` is stable while `symb_valid_o && !symb_ready_i`.
- `symb_valid_o` deasserts after a handshake if nothing new is loaded.

## Timing
- Reset values:
  - state IDLE, so `dbp_ready_o`=1 and `busy_o`=0.
  - `symb_valid_o`=0, `symb_o`='0, `pcnt`=0, `zrl`=0.
  - Optional `last_o`=0.
- Reset asserted mid-block discards the block and any pending run; nothing further is emitted.
- Latency: block accepted at cycle t; plane 0 is evaluated at t+1; its symbol, if nonzero, is valid at t+2.
- Throughput with `symb_ready_i`=1: one plane per cycle. A nonzero plane preceded by a run costs one extra cycle.
- Minimum block time is DATA_W+1 cycles in ENCODE, plus 1 cycle for FLUSH_ZR if the block ends in a run.
- `dbp_ready_o` is combinational from state only and never depends on `symb_ready_i`.
- A new block may be accepted while the last symbol of the previous block is still held in the output register.

## Configuration
- `EBPC_SYMB_LAST_EN`
  - Defined: adds output `last_o`, registered alongside `symb_o`. It is 1 on the final symbol of each block: the run symbol in FLUSH_ZR, or the symbol of plane DATA_W.
  - Undefined: no `last_o` port and no associated logic.

## Structure
- Added to `ebpc_pkg`:
  - `ZRL_SINGLE` (`3'b001`) and `ZRL_PREFIX` (`2'b01`).
  - Length constants for both run-symbol forms, as `symb_len_t`.
  - A `dbx_seq_state_e` enum holding IDLE, ENCODE and FLUSH_ZR.
- One sub-module: `dbx_compressor`, instantiated once and purely combinational.
- Sequencing, run counting and the output register live in this block.

## Test plan
All scenarios use DATA_W=8 and BLOCK_SIZE=8 (7-bit planes).
1. All planes 0 → exactly one symbol `{01,5'd7}`, len 7; `last_o`=1; then IDLE with `dbp_ready_o`=1.
2. All 9 planes = 7'h55 → `{01,5'd6}`, len 7, then uncompressed `{1,7'h55}`, len N.
3. Plane0=7'h01, plane1=7'h01, all others 0 → `001` for plane 0, then the DBX of plane 1 as `SINGLE_ONE_PREFIX` with pos=6, then `{01,5'd5}`.
4. Scenario 2 with `symb_ready_i`=0 for 5 cycles after the first valid → `symb_o` is held for 5 cycles, `pcnt` is frozen, and both symbols still arrive in order.
5. `MAX_ZRL`=4 with all planes zero → `{01,2'd2}`, `{01,2'd2}`, `001`.
6. `rst_ni` pulsed low at t+3 of scenario 2 → `symb_valid_o`=0 immediately, then IDLE. A following all-zero block produces only `{01,5'd7}`.
